fifo_assert_ctrl: RTL and testbench
===================================

# fifo_assert_ctrl

Synthesizable assertion-enable sequencer for the FIFO RTL checkers. It holds every checker group off through reset and a programmable init hold-off window. It also blanks all groups for a fixed window after a FIFO flush, and lets the bench pause or resume individual groups through a pulse request/ack interface. Its `assert_en` outputs gate the `disable iff` / enable terms of the FIFO assertion groups, so assertion control is cycle-accurate and clock-synchronous rather than driven by time-based system tasks.

## Interface
- `N_GRP`, 4, number of independently controlled assertion groups (1..16)
- `HOLDOFF`, 8, cycles assertions stay off after reset release (>= 1)
- `FLUSH_HOLD`, 4, cycles assertions stay off after a flush pulse (>= 1)
- `CNT_W`, 8, width of the saturating off-cycle counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  one-cycle pulse: FIFO is being flushed
- `grp_en_mask`  in  N_GRP  static per-group enable (1 = group allowed)
- `pause_req`  in  1  pulse: pause the groups in `req_mask`
- `resume_req`  in  1  pulse: resume the groups in `req_mask`
- `req_mask`  in  N_GRP  group select for pause/resume
- `req_ack`  out  1  one-cycle pulse acknowledging pause/resume
- `assert_en`  out  N_GRP  per-group assertion enable, registered
- `init_done`  out  1  high from the end of the first hold-off until the next reset
- `off_cycles`  out  CNT_W  saturating count of cycles spent in INIT or FLUSH

## Operation
- States: INIT, ACTIVE, FLUSH. Registers: `state`, hold-off counter `cnt` (width `clog2(max(HOLDOFF,FLUSH_HOLD))+1`), `paused[N_GRP]`, and the outputs.
- Reset (`rst`=1, asynchronous):
  - `state`=INIT, `cnt`=0, `paused`=0.
  - Outputs: `assert_en`=0, `req_ack`=0, `init_done`=0, `off_cycles`=0.
- INIT:
  - `cnt` increments each clock.
  - When `cnt`==HOLDOFF-1, the next state is ACTIVE, `cnt` is cleared and `init_done` is set.
  - `flush` is ignored in INIT.
- ACTIVE:
  - `flush`=1 → next state is FLUSH with `cnt` cleared.
  - Otherwise the state stays ACTIVE.
- FLUSH:
  - `cnt` increments each clock. When `cnt`==FLUSH_HOLD-1, the next state is ACTIVE.
  - A `flush` while in FLUSH clears `cnt` and restarts the window. This takes priority over the exit.
- Pause/resume are accepted in every state, including INIT and FLUSH:
  - `paused_next = (paused & ~(resume_req ? req_mask : 0)) | (pause_req ? req_mask : 0)`.
  - When both requests arrive in the same cycle, pause wins for the overlapping groups.
  - `req_ack` <= `pause_req | resume_req`: a one-cycle pulse, registered.
- Enable function:
  - `assert_en` <= (`state_next`==ACTIVE) ? (`grp_en_mask` & ~`paused_next`) : 0.
  - Groups masked off in `grp_en_mask` never enable.
- Off counter: `off_cycles` increments on each clock where `state` is INIT or FLUSH. It saturates at 2^CNT_W-1 and is cleared only by `rst`.

## Timing
- After reset release, the first rising edge with `rst`=0 is edge 1.
- `assert_en` and `init_done` go high at edge HOLDOFF. With HOLDOFF=8, they are visible after edge 8 and are never high before it.
- `flush` sampled at edge k drops `assert_en` to 0 after edge k. It is restored after edge k+FLUSH_HOLD.
- `pause_req`/`resume_req` sampled at edge k change `assert_en` and pulse `req_ack` after edge k. `req_ack` drops after edge k+1 unless a new request arrives.
- `grp_en_mask` changes take effect after the next edge. No other latency applies.
- `rst` asserted mid-operation clears all outputs immediately, without waiting for a clock edge. A new INIT hold-off then follows.
- Back-to-back requests on consecutive cycles are each acknowledged; no request is dropped.

## Test plan
- Reset release with HOLDOFF=8, `grp_en_mask`=4'hF → `assert_en`=0 through edge 7, 4'hF after edge 8, `init_done`=1, `off_cycles`=8.
- Flush at edge 20 (FLUSH_HOLD=4), second flush at edge 22 → `assert_en`=0 after edges 20..25, 4'hF after edge 26, `off_cycles`=14.
- `pause_req` with `req_mask`=4'b0101 at edge 30, then `resume_req` with `req_mask`=4'b0001 at edge 33 → `assert_en`=4'b1010 after edge 30, 4'b1011 after edge 33, `req_ack` high for one cycle after edges 30 and 33.
- Simultaneous `pause_req` and `resume_req` with `req_mask`=4'b0011 while `paused`=4'b0010 → `paused`=4'b0011, `assert_en`=4'b1100, single `req_ack` pulse.
- Pause of group 0 during INIT, then `grp_en_mask`=4'b0111 → after hold-off, `assert_en`=4'b0110.
- `rst` pulsed asynchronously mid-ACTIVE (between edges) → `assert_en`, `init_done`, `off_cycles` and `paused` are 0 immediately, and the full HOLDOFF sequence repeats.

Source files
------------

// File: rtl/fifo_assert_ctrl.sv
// ============================================================================
// fifo_assert_ctrl : clock-synchronous enable sequencer for FIFO checker groups
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_assert_ctrl #(
    parameter int N_GRP      = 4,
    parameter int HOLDOFF    = 8,
    parameter int FLUSH_HOLD = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [N_GRP-1:0] grp_en_mask,
    input  logic             pause_req,
    input  logic             resume_req,
    input  logic [N_GRP-1:0] req_mask,
    output logic             req_ack,
    output logic [N_GRP-1:0] assert_en,
    output logic             init_done,
    output logic [CNT_W-1:0] off_cycles
);

    localparam int HOLD_MAX = (HOLDOFF > FLUSH_HOLD) ? HOLDOFF : FLUSH_HOLD;
    localparam int CW       = $clog2(HOLD_MAX) + 1;

    localparam logic [CW-1:0]    C_INIT_LAST  = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0]    C_FLUSH_LAST = CW'(FLUSH_HOLD - 1);
    localparam logic [CW-1:0]    C_CNT_ONE    = CW'(1);
    localparam logic [CNT_W-1:0] C_OFF_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_OFF_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [N_GRP-1:0] paused;
    logic [N_GRP-1:0] paused_next;
    logic [N_GRP-1:0] en_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_INIT;
            cnt    <= '0;
            paused <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            paused <= paused_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_INIT: begin
                // flush is deliberately ignored until the first hold-off ends
                if (cnt == C_INIT_LAST) begin
                    state_next = ST_ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + C_CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                if (flush) begin
                    state_next = ST_FLUSH;
                    cnt_next   = '0;
                end
            end
            ST_FLUSH: begin
                // a repeated flush restarts the blanking window before any exit
                if (flush) begin
                    cnt_next = '0;
                end else if (cnt == C_FLUSH_LAST) begin
                    state_next = ST_ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + C_CNT_ONE;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // pause is OR-ed in last so it wins over a simultaneous resume
    always_comb begin
        paused_next = (paused & ~(resume_req ? req_mask : '0))
                    | (pause_req ? req_mask : '0);
        en_next     = (state_next == ST_ACTIVE) ? (grp_en_mask & ~paused_next) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            assert_en  <= '0;
            req_ack    <= 1'b0;
            init_done  <= 1'b0;
            off_cycles <= '0;
        end else begin
            assert_en <= en_next;
            req_ack   <= pause_req | resume_req;
            if (state_next == ST_ACTIVE) begin
                init_done <= 1'b1;
            end
            if ((state != ST_ACTIVE) && (off_cycles != C_OFF_MAX)) begin
                off_cycles <= off_cycles + C_OFF_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_assert_ctrl.sv
// ============================================================================
// tb_fifo_assert_ctrl : directed plan scenarios plus randomized run vs. model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_assert_ctrl;

    localparam int N_GRP      = 4;
    localparam int HOLDOFF    = 8;
    localparam int FLUSH_HOLD = 4;
    localparam int CNT_W      = 8;
    localparam int OFF_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [N_GRP-1:0] grp_en_mask = '1;
    logic             pause_req = 1'b0;
    logic             resume_req = 1'b0;
    logic [N_GRP-1:0] req_mask = '0;
    logic             req_ack;
    logic [N_GRP-1:0] assert_en;
    logic             init_done;
    logic [CNT_W-1:0] off_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: elapsed edges since release, remaining blanked edges
    int               m_edges;
    int               m_left;
    int               m_off;
    logic [N_GRP-1:0] m_paused;

    fifo_assert_ctrl #(
        .N_GRP     (N_GRP),
        .HOLDOFF   (HOLDOFF),
        .FLUSH_HOLD(FLUSH_HOLD),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .grp_en_mask(grp_en_mask),
        .pause_req  (pause_req),
        .resume_req (resume_req),
        .req_mask   (req_mask),
        .req_ack    (req_ack),
        .assert_en  (assert_en),
        .init_done  (init_done),
        .off_cycles (off_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges  = 0;
        m_left   = 0;
        m_off    = 0;
        m_paused = '0;
    endtask

    task automatic check_all(input string tag);
        logic             m_active;
        logic [N_GRP-1:0] m_en;
        m_active = (m_edges >= HOLDOFF) && (m_left == 0);
        m_en     = m_active ? (grp_en_mask & ~m_paused) : '0;
        check({tag, ".assert_en"},  32'(assert_en),  32'(m_en));
        check({tag, ".init_done"},  32'(init_done),  32'(m_edges >= HOLDOFF));
        check({tag, ".req_ack"},    32'(req_ack),    32'(pause_req | resume_req));
        check({tag, ".off_cycles"}, 32'(off_cycles), 32'(m_off));
    endtask

    // drive inputs, take one edge, advance the model, then sample
    task automatic step(input string tag, input logic f, input logic p, input logic r,
                        input logic [N_GRP-1:0] rm, input logic [N_GRP-1:0] gm);
        flush       = f;
        pause_req   = p;
        resume_req  = r;
        req_mask    = rm;
        grp_en_mask = gm;
        @(posedge clk);
        if ((m_edges < HOLDOFF) || (m_left > 0)) begin
            m_off = (m_off < OFF_MAX) ? m_off + 1 : OFF_MAX;
        end
        if (m_edges < HOLDOFF) begin
            m_edges++;
        end else if (f) begin
            m_left = FLUSH_HOLD;
        end else if (m_left > 0) begin
            m_left--;
        end
        for (int g = 0; g < N_GRP; g++) begin
            if (p && rm[g])      m_paused[g] = 1'b1;
            else if (r && rm[g]) m_paused[g] = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input logic [N_GRP-1:0] gm);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, '0, gm);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, ".rst_en"},   32'(assert_en),  32'd0);
        check({tag, ".rst_done"}, 32'(init_done),  32'd0);
        check({tag, ".rst_off"},  32'(off_cycles), 32'd0);
        check({tag, ".rst_ack"},  32'(req_ack),    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check("reset.assert_en",  32'(assert_en),  32'd0);
        check("reset.init_done",  32'(init_done),  32'd0);
        check("reset.off_cycles", 32'(off_cycles), 32'd0);
        check("reset.req_ack",    32'(req_ack),    32'd0);
        rst = 1'b0;

        // hold-off: edges 1..7 off, on after edge 8
        idle(7, 4'hF);
        check("holdoff.e7", 32'(assert_en), 32'h0);
        idle(1, 4'hF);
        check("holdoff.e8_en",   32'(assert_en),  32'hF);
        check("holdoff.e8_done", 32'(init_done),  32'd1);
        check("holdoff.e8_off",  32'(off_cycles), 32'd8);

        // flush at 20, re-flush at 22, restored after 26
        idle(11, 4'hF);
        step("flush20", 1'b1, 1'b0, 1'b0, '0, 4'hF);
        check("flush.e20", 32'(assert_en), 32'h0);
        idle(1, 4'hF);
        step("flush22", 1'b1, 1'b0, 1'b0, '0, 4'hF);
        idle(3, 4'hF);
        check("flush.e25", 32'(assert_en), 32'h0);
        idle(1, 4'hF);
        check("flush.e26_en",  32'(assert_en),  32'hF);
        check("flush.e26_off", 32'(off_cycles), 32'd14);

        // pause 0101 at 30, resume 0001 at 33
        idle(3, 4'hF);
        step("pause30", 1'b0, 1'b1, 1'b0, 4'b0101, 4'hF);
        check("pause.e30_en",  32'(assert_en), 32'b1010);
        check("pause.e30_ack", 32'(req_ack),   32'd1);
        idle(1, 4'hF);
        check("pause.e31_ack", 32'(req_ack), 32'd0);
        idle(1, 4'hF);
        step("resume33", 1'b0, 1'b0, 1'b1, 4'b0001, 4'hF);
        check("resume.e33_en",  32'(assert_en), 32'b1011);
        check("resume.e33_ack", 32'(req_ack),   32'd1);

        // simultaneous requests, paused=0010 beforehand
        step("clr", 1'b0, 1'b0, 1'b1, 4'hF, 4'hF);
        step("set", 1'b0, 1'b1, 1'b0, 4'b0010, 4'hF);
        step("both", 1'b0, 1'b1, 1'b1, 4'b0011, 4'hF);
        check("both.en", 32'(assert_en), 32'b1100);
        idle(1, 4'hF);
        check("both.single_ack", 32'(req_ack), 32'd0);

        // async reset mid-ACTIVE, pause group 0 during INIT, narrowed mask
        async_reset("mid");
        step("init_pause", 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0111);
        step("init_flush", 1'b1, 1'b0, 1'b0, '0, 4'b0111);
        idle(HOLDOFF - 3, 4'b0111);
        check("reinit.e7", 32'(assert_en), 32'h0);
        idle(1, 4'b0111);
        check("reinit.e8_en",  32'(assert_en),  32'b0110);
        check("reinit.e8_off", 32'(off_cycles), 32'd8);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [N_GRP-1:0] gm;
            gm = ($urandom_range(0, 3) == 0) ? N_GRP'($urandom) : 4'hF;
            if ($urandom_range(0, 999) == 0) begin
                async_reset("rnd");
            end
            step("rnd",
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 N_GRP'($urandom), gm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
